// File: rtl/sram_bus_arbiter_pkg.sv
// Shared CPU-level constants for the SRAM bus arbiter: master owner ids and
// the lock-state encoding.
package sram_bus_arbiter_pkg;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/resp_owner_fifo.sv
// In-order FIFO of 1-bit owner ids. Each entry records which master issued an
// accepted request, so responses can be routed back in order.
module resp_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Merges the inst-fetch and data SRAM-like ports onto one bus. Data has fixed
// priority; a stalled request locks the grant until the slave accepts it.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    lock_state_e state, state_next;
    logic        lock_owner, lock_owner_next;
    logic        grant;
    logic        grant_req;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_head;
    logic        accept;
    logic        resp;

    always_comb begin
        grant = data_sram_req ? OWN_DATA : OWN_INST;
        if (state == LOCKED) grant = lock_owner;
    end

    assign grant_req = (grant == OWN_DATA) ? data_sram_req : inst_sram_req;
    assign bus_req   = resetn && grant_req && !fifo_full;
    assign bus_wr    = (grant == OWN_DATA) ? data_sram_wr    : inst_sram_wr;
    assign bus_size  = (grant == OWN_DATA) ? data_sram_size  : inst_sram_size;
    assign bus_wstrb = (grant == OWN_DATA) ? data_sram_wstrb : inst_sram_wstrb;
    assign bus_addr  = (grant == OWN_DATA) ? data_sram_addr  : inst_sram_addr;
    assign bus_wdata = (grant == OWN_DATA) ? data_sram_wdata : inst_sram_wdata;

    assign accept            = bus_req && bus_addr_ok;
    assign inst_sram_addr_ok = accept && (grant == OWN_INST);
    assign data_sram_addr_ok = accept && (grant == OWN_DATA);

    // A response with nothing outstanding is dropped silently.
    assign resp              = resetn && bus_data_ok && !fifo_empty;
    assign inst_sram_data_ok = resp && (fifo_head == OWN_INST);
    assign data_sram_data_ok = resp && (fifo_head == OWN_DATA);
    assign inst_sram_rdata   = bus_rdata;
    assign data_sram_rdata   = bus_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= UNLOCKED;
            lock_owner <= OWN_INST;
        end else begin
            state      <= state_next;
            lock_owner <= lock_owner_next;
        end
    end

    always_comb begin
        state_next      = state;
        lock_owner_next = lock_owner;
        case (state)
            UNLOCKED: begin
                if (bus_req && !bus_addr_ok) begin
                    state_next      = LOCKED;
                    lock_owner_next = grant;
                end
            end
            LOCKED: begin
                if (bus_addr_ok) state_next = UNLOCKED;
            end
            default: state_next = UNLOCKED;
        endcase
    end

    resp_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .din    (grant),
        .pop    (resp),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (fifo_head)
    );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: a queue-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_sram_bus_arbiter;

    localparam int OUTSTANDING = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding owners in a queue (1 = data master) and the
    // owner of a request that is waiting for the slave to accept it.
    bit owner_q[$];
    bit held;
    bit held_owner;

    always @(negedge clk) begin
        bit e_grant, e_req, e_pop, e_head, e_acc;
        e_grant = held ? held_owner : data_sram_req;
        e_req   = resetn && (e_grant ? data_sram_req : inst_sram_req)
                  && (owner_q.size() < OUTSTANDING);
        e_acc   = e_req && bus_addr_ok;
        e_pop   = resetn && bus_data_ok && (owner_q.size() > 0);
        e_head  = (owner_q.size() > 0) ? owner_q[0] : 1'b0;

        chk("m_bus_req", 32'(bus_req), 32'(e_req));
        if (e_req) begin
            chk("m_bus_addr", bus_addr, e_grant ? data_sram_addr : inst_sram_addr);
            chk("m_bus_wr", 32'(bus_wr), 32'(e_grant ? data_sram_wr : inst_sram_wr));
            chk("m_bus_wstrb", 32'(bus_wstrb), 32'(e_grant ? data_sram_wstrb : inst_sram_wstrb));
            chk("m_bus_size", 32'(bus_size), 32'(e_grant ? data_sram_size : inst_sram_size));
            chk("m_bus_wdata", bus_wdata, e_grant ? data_sram_wdata : inst_sram_wdata);
        end
        chk("m_inst_addr_ok", 32'(inst_sram_addr_ok), 32'(e_acc && !e_grant));
        chk("m_data_addr_ok", 32'(data_sram_addr_ok), 32'(e_acc && e_grant));
        chk("m_inst_data_ok", 32'(inst_sram_data_ok), 32'(e_pop && !e_head));
        chk("m_data_data_ok", 32'(data_sram_data_ok), 32'(e_pop && e_head));
        chk("m_inst_rdata", inst_sram_rdata, bus_rdata);
        chk("m_data_rdata", data_sram_rdata, bus_rdata);

        // Inputs stay stable until after the next rising edge, so advance now.
        if (!resetn) begin
            owner_q.delete();
            held = 1'b0;
        end else begin
            if (e_pop) void'(owner_q.pop_front());
            if (e_acc) owner_q.push_back(e_grant);
            if (bus_addr_ok) held = 1'b0;
            else if (e_req && !held) begin
                held       = 1'b1;
                held_owner = e_grant;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_sram_req = 0; data_sram_req = 0;
        inst_sram_wr = 0; data_sram_wr = 0;
        bus_addr_ok = 0; bus_data_ok = 0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            step(); idle(); bus_data_ok = 1; bus_rdata = 32'hA000_0000 + 32'(i);
        end
        step(); idle();
    endtask

    initial begin
        resetn = 0;
        idle();
        inst_sram_size = 2'd2; data_sram_size = 2'd2;
        inst_sram_wstrb = 4'h0; data_sram_wstrb = 4'h0;
        inst_sram_addr = 32'h0; data_sram_addr = 32'h0;
        inst_sram_wdata = 32'h0; data_sram_wdata = 32'h0;
        bus_rdata = 32'h0;
        inst_sram_req = 1; bus_addr_ok = 1;
        @(negedge clk);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
        step(); idle(); resetn = 1;

        // Inst read, response two cycles after accept.
        step(); inst_sram_req = 1; inst_sram_addr = 32'h1C00_0000; bus_addr_ok = 1;
        @(negedge clk);
        chk("rd_bus_addr", bus_addr, 32'h1C00_0000);
        chk("rd_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        step(); idle();
        step(); bus_data_ok = 1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rd_inst_data_ok", 32'(inst_sram_data_ok), 32'd1);
        chk("rd_inst_rdata", inst_sram_rdata, 32'h1234_5678);
        chk("rd_data_data_ok", 32'(data_sram_data_ok), 32'd0);
        step(); idle();

        // Priority: data wins, inst follows next cycle.
        step(); inst_sram_req = 1; inst_sram_addr = 32'h100;
        data_sram_req = 1; data_sram_addr = 32'h200; bus_addr_ok = 1;
        @(negedge clk);
        chk("pri_bus_addr", bus_addr, 32'h200);
        chk("pri_data_addr_ok", 32'(data_sram_addr_ok), 32'd1);
        chk("pri_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
        step(); data_sram_req = 0;
        @(negedge clk);
        chk("pri_inst_next", 32'(inst_sram_addr_ok), 32'd1);
        drain(2);

        // Lock: stalled inst request holds the grant against a later data req.
        inst_sram_req = 1; inst_sram_addr = 32'h300; data_sram_addr = 32'h400;
        step(); data_sram_req = 1;
        @(negedge clk);
        chk("lock_c2_addr", bus_addr, 32'h300);
        step();
        @(negedge clk);
        chk("lock_c3_addr", bus_addr, 32'h300);
        step(); bus_addr_ok = 1;
        @(negedge clk);
        chk("lock_acc_addr", bus_addr, 32'h300);
        chk("lock_inst_ok", 32'(inst_sram_addr_ok), 32'd1);
        step(); inst_sram_req = 0;
        @(negedge clk);
        chk("lock_data_ok", 32'(data_sram_addr_ok), 32'd1);
        drain(2);

        // Full: third request blocked, still blocked on the pop cycle.
        inst_sram_req = 1; inst_sram_addr = 32'h500; bus_addr_ok = 1;
        step(); inst_sram_req = 0; data_sram_req = 1; data_sram_addr = 32'h600;
        step(); data_sram_req = 0; inst_sram_req = 1; inst_sram_addr = 32'h700;
        @(negedge clk);
        chk("full_bus_req", 32'(bus_req), 32'd0);
        step(); bus_data_ok = 1; bus_rdata = 32'hCAFE_0001;
        @(negedge clk);
        chk("full_pop_bus_req", 32'(bus_req), 32'd0);
        chk("full_pop_inst_dok", 32'(inst_sram_data_ok), 32'd1);
        step(); bus_data_ok = 0;
        @(negedge clk);
        chk("full_after_req", 32'(bus_req), 32'd1);
        chk("full_after_ok", 32'(inst_sram_addr_ok), 32'd1);
        step(); idle();
        drain(2);

        // Ordering: inst read then data write; responses follow issue order.
        inst_sram_req = 1; inst_sram_addr = 32'h800; bus_addr_ok = 1;
        step(); inst_sram_req = 0; data_sram_req = 1; data_sram_wr = 1;
        data_sram_wstrb = 4'hF; data_sram_addr = 32'h900; data_sram_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("ord_bus_wr", 32'(bus_wr), 32'd1);
        chk("ord_bus_wstrb", 32'(bus_wstrb), 32'hF);
        step(); idle(); bus_data_ok = 1;
        @(negedge clk);
        chk("ord_first_inst", 32'(inst_sram_data_ok), 32'd1);
        step(); bus_data_ok = 1;
        @(negedge clk);
        chk("ord_second_data", 32'(data_sram_data_ok), 32'd1);
        chk("ord_second_inst", 32'(inst_sram_data_ok), 32'd0);
        step(); idle();

        // Reset mid-operation with two outstanding.
        inst_sram_req = 1; bus_addr_ok = 1;
        step(); inst_sram_req = 0; data_sram_req = 1;
        step(); data_sram_req = 0; inst_sram_req = 1; bus_data_ok = 1;
        #2 resetn = 0;
        #1;
        chk("rst_mid_bus_req", 32'(bus_req), 32'd0);
        chk("rst_mid_inst_aok", 32'(inst_sram_addr_ok), 32'd0);
        chk("rst_mid_inst_dok", 32'(inst_sram_data_ok), 32'd0);
        chk("rst_mid_data_dok", 32'(data_sram_data_ok), 32'd0);
        step(); idle(); resetn = 1;
        step(); bus_data_ok = 1;
        @(negedge clk);
        chk("rst_spur_inst", 32'(inst_sram_data_ok), 32'd0);
        chk("rst_spur_data", 32'(data_sram_data_ok), 32'd0);

        // Empty-FIFO response without reset: dropped, count must not underflow.
        step(); idle(); bus_data_ok = 1;
        @(negedge clk);
        chk("empty_inst_dok", 32'(inst_sram_data_ok), 32'd0);
        chk("empty_data_dok", 32'(data_sram_data_ok), 32'd0);
        step(); idle(); inst_sram_req = 1; bus_addr_ok = 1;
        @(negedge clk);
        chk("empty_then_req", 32'(bus_req), 32'd1);
        step();
        step();
        @(negedge clk);
        chk("empty_then_full", 32'(bus_req), 32'd0);
        step(); idle();
        drain(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
